// File: rtl/bs_issue_fifo.sv
// bs_issue_fifo: request FIFO feeding an external barrel shifter, with a
// registered result stage. Optional macro BS_ISSUE_STATS_EN adds issued_cnt.
module bs_issue_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [7:0]               in_a,
    input  logic [2:0]               in_s,
    output logic [7:0]               bs_a,
    output logic [2:0]               bs_s,
    input  logic [7:0]               bs_y,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               out_y,
    output logic [2:0]               out_s,
    output logic [$clog2(DEPTH):0]   count
`ifdef BS_ISSUE_STATS_EN
    ,
    output logic [15:0]              issued_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [10:0]   mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ov_q, ov_d;
    logic [7:0]    y_q, y_d;
    logic [2:0]    s_q, s_d;
    logic          push, pop, nempty;
    logic [10:0]   head;

`ifdef BS_ISSUE_STATS_EN
    logic [15:0]   stat_q, stat_d;
`endif

    // Handshake decode: acceptance ignores same-cycle pops.
    always_comb begin
        nempty = (count_q != '0);
        push   = in_valid && (count_q < FULL);
        pop    = nempty && (!ov_q || out_ready);
        head   = mem_q[rptr_q];
    end

    // Shifter operands come straight from the FIFO head, zero when empty.
    always_comb begin
        bs_a = 8'h00;
        bs_s = 3'b000;
        if (nempty) begin
            bs_a = head[7:0];
            bs_s = head[10:8];
        end
    end

    // Next-state for pointers, occupancy and the result register.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ov_d    = ov_q;
        y_d     = y_q;
        s_d     = s_q;
        if (push) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (pop) begin
            rptr_d = rptr_q + AW'(1);
            ov_d   = 1'b1;
            y_d    = bs_y;
            s_d    = bs_s;
        end else if (ov_q && out_ready) begin
            ov_d = 1'b0;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control and result state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ov_q    <= 1'b0;
            y_q     <= 8'h00;
            s_q     <= 3'b000;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ov_q    <= ov_d;
            y_q     <= y_d;
            s_q     <= s_d;
        end
    end

    // Entry storage; contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_q[wptr_q] <= {in_s, in_a};
        end
    end

`ifdef BS_ISSUE_STATS_EN
    // Issue counter wraps naturally at 16 bits.
    always_comb begin
        stat_d = stat_q;
        if (pop) begin
            stat_d = stat_q + 16'd1;
        end
    end

    // Issue counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_q <= 16'h0000;
        end else begin
            stat_q <= stat_d;
        end
    end

    assign issued_cnt = stat_q;
`endif

    assign in_ready  = (count_q < FULL);
    assign out_valid = ov_q;
    assign out_y     = y_q;
    assign out_s     = s_q;
    assign count     = count_q;

endmodule

// File: tb/tb_bs_issue_fifo.sv
// Testbench for bs_issue_fifo: directed vector table, hand sequences and
// randomized traffic against a queue-based reference model.
module tb_bs_issue_fifo;

    localparam int DEPTH = 4;
    localparam int CW = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [7:0]    in_a = 8'h00;
    logic [2:0]    in_s = 3'b000;
    logic [7:0]    bs_a;
    logic [2:0]    bs_s;
    logic [7:0]    bs_y;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [7:0]    out_y;
    logic [2:0]    out_s;
    logic [CW-1:0] count;
`ifdef BS_ISSUE_STATS_EN
    logic [15:0]   issued_cnt;
`endif

    bs_issue_fifo #(.DEPTH(DEPTH)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_a(in_a),
        .in_s(in_s),
        .bs_a(bs_a),
        .bs_s(bs_s),
        .bs_y(bs_y),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_y(out_y),
        .out_s(out_s),
        .count(count)
`ifdef BS_ISSUE_STATS_EN
        ,
        .issued_cnt(issued_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural barrel shifter (rotate left) attached to the DUT.
    logic [15:0] dbl;
    assign dbl  = {bs_a, bs_a} << bs_s;
    assign bs_y = dbl[15:8];

    int ncmp = 0;
    int nfail = 0;

    // Reference model state
    logic [10:0] mq[$];
    logic        m_ov = 1'b0;
    logic [7:0]  m_y = 8'h00;
    logic [2:0]  m_s = 3'b000;
    int          m_pops = 0;

    function automatic logic [7:0] rotl_ref(input logic [7:0] a,
                                            input logic [2:0] s);
        logic [7:0] y;
        y = 8'h00;
        for (int i = 0; i < 8; i++) begin
            y[(i + int'(s)) % 8] = a[i];
        end
        return y;
    endfunction

    task automatic chk(input string n, input int act, input int exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h want %0h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic do_pop, do_push;
        logic [10:0] h;
        if (rst) begin
            mq.delete();
            m_ov = 1'b0;
            m_y = 8'h00;
            m_s = 3'b000;
            m_pops = 0;
        end else begin
            do_push = in_valid && (mq.size() < DEPTH);
            do_pop = (mq.size() > 0) && (!m_ov || out_ready);
            if (do_pop) begin
                h = mq.pop_front();
                m_y = rotl_ref(h[7:0], h[10:8]);
                m_s = h[10:8];
                m_ov = 1'b1;
                m_pops++;
            end else if (m_ov && out_ready) begin
                m_ov = 1'b0;
            end
            if (do_push) mq.push_back({in_s, in_a});
        end
    endtask

    task automatic check_model();
        logic [10:0] h;
        h = (mq.size() > 0) ? mq[0] : 11'h000;
        chk("m.count", int'(count), mq.size());
        chk("m.in_ready", int'(in_ready), int'(mq.size() < DEPTH));
        chk("m.out_valid", int'(out_valid), int'(m_ov));
        chk("m.out_y", int'(out_y), int'(m_y));
        chk("m.out_s", int'(out_s), int'(m_s));
        chk("m.bs_a", int'(bs_a), int'(h[7:0]));
        chk("m.bs_s", int'(bs_s), int'(h[10:8]));
`ifdef BS_ISSUE_STATS_EN
        chk("m.issued_cnt", int'(issued_cnt), m_pops % 65536);
`endif
    endtask

    task automatic apply(input logic r, input logic iv, input logic [7:0] a,
                         input logic [2:0] s, input logic ordy);
        rst = r;
        in_valid = iv;
        in_a = a;
        in_s = s;
        out_ready = ordy;
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    typedef struct {
        logic          r;
        logic          iv;
        logic [7:0]    a;
        logic [2:0]    s;
        logic          ordy;
        logic [CW-1:0] ecnt;
        logic          eov;
        logic [7:0]    ey;
        logic [2:0]    es;
        logic          erdy;
    } vec_t;

    vec_t vecs[12];

    initial begin
        // rst iv a s or | cnt ov y s rdy
        vecs[0]  = '{1'b1, 1'b0, 8'h00, 3'd0, 1'b1, 3'd0, 1'b0, 8'h00, 3'd0, 1'b1};
        vecs[1]  = '{1'b0, 1'b1, 8'hB1, 3'd3, 1'b1, 3'd1, 1'b0, 8'h00, 3'd0, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 8'h00, 3'd0, 1'b1, 3'd0, 1'b1, 8'h8D, 3'd3, 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 8'h00, 3'd0, 1'b1, 3'd0, 1'b0, 8'h8D, 3'd3, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 8'h10, 3'd1, 1'b0, 3'd1, 1'b0, 8'h8D, 3'd3, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 8'h20, 3'd2, 1'b0, 3'd1, 1'b1, 8'h20, 3'd1, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 8'h30, 3'd3, 1'b0, 3'd2, 1'b1, 8'h20, 3'd1, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 8'h40, 3'd4, 1'b0, 3'd3, 1'b1, 8'h20, 3'd1, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 8'h50, 3'd5, 1'b0, 3'd4, 1'b1, 8'h20, 3'd1, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 8'h60, 3'd6, 1'b0, 3'd4, 1'b1, 8'h20, 3'd1, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 8'h00, 3'd0, 1'b1, 3'd3, 1'b1, 8'h80, 3'd2, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 8'h00, 3'd0, 1'b1, 3'd2, 1'b1, 8'h81, 3'd3, 1'b1};

        for (int i = 0; i < 12; i++) begin
            apply(vecs[i].r, vecs[i].iv, vecs[i].a, vecs[i].s, vecs[i].ordy);
            chk($sformatf("vec%0d.count", i), int'(count), int'(vecs[i].ecnt));
            chk($sformatf("vec%0d.out_valid", i), int'(out_valid), int'(vecs[i].eov));
            chk($sformatf("vec%0d.out_y", i), int'(out_y), int'(vecs[i].ey));
            chk($sformatf("vec%0d.out_s", i), int'(out_s), int'(vecs[i].es));
            chk($sformatf("vec%0d.in_ready", i), int'(in_ready), int'(vecs[i].erdy));
        end

        // Drain order: results 02,04,06,08 on consecutive cycles.
        apply(1'b1, 1'b0, 8'h00, 3'd0, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            apply(1'b0, 1'b1, 8'(i), 3'd1, 1'b0);
        end
        chk("drain.first", int'(out_y), 8'h02);
        for (int i = 2; i <= 4; i++) begin
            apply(1'b0, 1'b0, 8'h00, 3'd0, 1'b1);
            chk($sformatf("drain.y%0d", i), int'(out_y), 2 * i);
            chk($sformatf("drain.v%0d", i), int'(out_valid), 1);
        end
        apply(1'b0, 1'b0, 8'h00, 3'd0, 1'b1);
        chk("drain.idle", int'(out_valid), 0);

        // Simultaneous push and pop holds occupancy at 2.
        apply(1'b1, 1'b0, 8'h00, 3'd0, 1'b0);
        apply(1'b0, 1'b1, 8'hA0, 3'd1, 1'b0);
        apply(1'b0, 1'b1, 8'hA1, 3'd2, 1'b0);
        apply(1'b0, 1'b1, 8'hA2, 3'd3, 1'b0);
        chk("pp.setup", int'(count), 2);
        for (int i = 0; i < 10; i++) begin
            apply(1'b0, 1'b1, 8'hC0 + 8'(i), 3'(i), 1'b1);
            chk($sformatf("pp.count%0d", i), int'(count), 2);
        end

        // Mid-operation reset with count=3 and a held result.
        apply(1'b0, 1'b1, 8'h77, 3'd5, 1'b0);
        chk("mr.pre_count", int'(count), 3);
        chk("mr.pre_ov", int'(out_valid), 1);
        apply(1'b1, 1'b1, 8'h55, 3'd2, 1'b1);
        chk("mr.count", int'(count), 0);
        chk("mr.ov", int'(out_valid), 0);
        chk("mr.y", int'(out_y), 0);
        chk("mr.bs_a", int'(bs_a), 0);
        apply(1'b0, 1'b1, 8'hB1, 3'd3, 1'b1);
        apply(1'b0, 1'b0, 8'h00, 3'd0, 1'b1);
        chk("mr.post_ov", int'(out_valid), 1);
        chk("mr.post_y", int'(out_y), 8'h8D);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            apply($urandom_range(0, 59) == 0, 1'($urandom_range(0, 1)),
                  8'($urandom), 3'($urandom), $urandom_range(0, 3) != 0);
        end

`ifdef BS_ISSUE_STATS_EN
        // Counter wrap after 65,537 pops.
        apply(1'b1, 1'b0, 8'h00, 3'd0, 1'b1);
        chk("st.reset", int'(issued_cnt), 0);
        for (int i = 0; i < 70000 && m_pops < 65537; i++) begin
            apply(1'b0, 1'b1, 8'($urandom), 3'($urandom),
                  m_pops < 65536);
        end
        chk("st.pops", m_pops, 65537);
        chk("st.wrap", int'(issued_cnt), 1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
